// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction fields, decode helpers and pipeline-register types for the 5-stage core
package cpu_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LOAD = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LI = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hf;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int FIELD_W = 4;
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;
  typedef struct packed {
    logic valid;
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;
  typedef struct packed {
    logic valid;
    logic [3:0] op;
    logic [3:0] rd;
  } dst_t;
  localparam instr_t BUBBLE = '0;
  function automatic instr_t decode(input logic [15:0] w);
    return '{valid: 1'b1, op: w[OP_LSB +: FIELD_W], rd: w[RD_LSB +: FIELD_W],
             rs1: w[RS1_LSB +: FIELD_W], rs2: w[RS2_LSB +: FIELD_W]};
  endfunction
  function automatic dst_t dst(input instr_t i);
    return '{valid: i.valid, op: i.op, rd: i.rd};
  endfunction
  function automatic logic uses_rs1(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD, OP_STORE};
  endfunction
  function automatic logic uses_rs2(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STORE};
  endfunction
  function automatic logic writes_rd(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD, OP_LI};
  endfunction
endpackage

// File: rtl/pipelined_cpu_hazard_unit.sv
// pipelined_cpu_hazard_unit: EX operand forward selects and load-use stall detection
module pipelined_cpu_hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input logic id_valid,
  input logic [3:0] id_op,
  input logic [REG_AW-1:0] id_rs1,
  input logic [REG_AW-1:0] id_rs2,
  input logic [REG_AW-1:0] ex_rs1,
  input logic [REG_AW-1:0] ex_rs2,
  input dst_t ex,
  input dst_t mem,
  input dst_t wb,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic stall
);
  function automatic logic [1:0] fwd_sel(input dst_t m, input dst_t w, input logic [REG_AW-1:0] rs);
    return (m.valid && writes_rd(m.op) && m.op != OP_LOAD && m.rd[REG_AW-1:0] == rs) ? FWD_MEM
         : (w.valid && writes_rd(w.op) && w.rd[REG_AW-1:0] == rs) ? FWD_WB : FWD_REG;
  endfunction
  always_comb begin
    fwd_a = fwd_sel(mem, wb, ex_rs1);
    fwd_b = fwd_sel(mem, wb, ex_rs2);
    stall = id_valid && ex.valid && ex.op == OP_LOAD &&
            ((uses_rs1(id_op) && ex.rd[REG_AW-1:0] == id_rs1) ||
             (uses_rs2(id_op) && ex.rd[REG_AW-1:0] == id_rs2));
  end
endmodule

// File: rtl/pipelined_cpu_core.sv
// pipelined_cpu_core: 5-stage in-order CPU with forwarding, load-use stall, HALT and preload/debug ports
module pipelined_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset_n,
  input logic prog_we,
  input logic [IMEM_AW-1:0] prog_addr,
  input logic [15:0] prog_data,
  input logic dmem_we,
  input logic [DMEM_AW-1:0] dmem_addr,
  input logic [DATA_W-1:0] dmem_wdata,
  input logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [IMEM_AW-1:0] pc,
  output logic halted,
  output logic [CNT_W-1:0] retired_cnt
);
  logic [15:0] imem [2**IMEM_AW];
  logic [DATA_W-1:0] dmem [2**DMEM_AW];
  logic [DATA_W-1:0] rf [2**REG_AW];
  logic [IMEM_AW-1:0] pc_q, pc_d;
  instr_t ifid_q, ifid_d, idex_q, idex_d;
  dst_t exmem_q, exmem_d, memwb_q, memwb_d;
  logic [DATA_W-1:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic [DATA_W-1:0] exmem_res_q, exmem_res_d, exmem_sd_q, exmem_sd_d;
  logic [DMEM_AW-1:0] exmem_addr_q, exmem_addr_d;
  logic [DATA_W-1:0] memwb_res_q, memwb_res_d;
  logic halting_q, halting_d, halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] fwd_a, fwd_b;
  logic stall, stop, wb_we;
  logic [DATA_W-1:0] op_a, op_b, imm;
  pipelined_cpu_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_valid(ifid_q.valid),
    .id_op(ifid_q.op),
    .id_rs1(ifid_q.rs1[REG_AW-1:0]),
    .id_rs2(ifid_q.rs2[REG_AW-1:0]),
    .ex_rs1(idex_q.rs1[REG_AW-1:0]),
    .ex_rs2(idex_q.rs2[REG_AW-1:0]),
    .ex(dst(idex_q)),
    .mem(exmem_q),
    .wb(memwb_q),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .stall(stall)
  );
  always_comb begin
    stop = (ifid_q.valid && ifid_q.op == OP_HALT) || halting_q;
    wb_we = memwb_q.valid && writes_rd(memwb_q.op);
    pc_d = (stop || stall) ? pc_q : pc_q + 1'b1;
    ifid_d = stall ? ifid_q : stop ? BUBBLE : decode(imem[pc_q]);
    halting_d = stop;
    idex_d = stall ? BUBBLE : ifid_q;
    idex_a_d = (wb_we && memwb_q.rd[REG_AW-1:0] == ifid_q.rs1[REG_AW-1:0]) ? memwb_res_q
             : rf[ifid_q.rs1[REG_AW-1:0]];
    idex_b_d = (wb_we && memwb_q.rd[REG_AW-1:0] == ifid_q.rs2[REG_AW-1:0]) ? memwb_res_q
             : rf[ifid_q.rs2[REG_AW-1:0]];
    imm = DATA_W'({idex_q.rs1, idex_q.rs2});
    op_a = fwd_a == FWD_MEM ? exmem_res_q : fwd_a == FWD_WB ? memwb_res_q : idex_a_q;
    op_b = fwd_b == FWD_MEM ? exmem_res_q : fwd_b == FWD_WB ? memwb_res_q : idex_b_q;
    exmem_d = dst(idex_q);
    exmem_res_d = idex_q.op == OP_ADD ? op_a + op_b
                : idex_q.op == OP_SUB ? op_a - op_b
                : idex_q.op == OP_AND ? op_a & op_b
                : idex_q.op == OP_OR ? op_a | op_b
                : idex_q.op == OP_XOR ? op_a ^ op_b
                : idex_q.op == OP_LI ? imm : '0;
    exmem_addr_d = op_a[DMEM_AW-1:0];
    exmem_sd_d = op_b;
    memwb_d = exmem_q;
    memwb_res_d = exmem_q.op == OP_LOAD ? dmem[exmem_addr_q] : exmem_res_q;
    halted_d = halted_q || (memwb_q.valid && memwb_q.op == OP_HALT);
    cnt_d = cnt_q + CNT_W'(memwb_q.valid);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= '0;
      ifid_q <= '0;
      idex_q <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      idex_a_q <= '0;
      idex_b_q <= '0;
      exmem_res_q <= '0;
      exmem_sd_q <= '0;
      exmem_addr_q <= '0;
      memwb_res_q <= '0;
      halting_q <= 1'b0;
      halted_q <= 1'b0;
      cnt_q <= '0;
      for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
    end else begin
      pc_q <= pc_d;
      ifid_q <= ifid_d;
      idex_q <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      idex_a_q <= idex_a_d;
      idex_b_q <= idex_b_d;
      exmem_res_q <= exmem_res_d;
      exmem_sd_q <= exmem_sd_d;
      exmem_addr_q <= exmem_addr_d;
      memwb_res_q <= memwb_res_d;
      halting_q <= halting_d;
      halted_q <= halted_d;
      cnt_q <= cnt_d;
      if (wb_we) rf[memwb_q.rd[REG_AW-1:0]] <= memwb_res_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n && prog_we) imem[prog_addr] <= prog_data;
    if (!reset_n && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    else if (reset_n && exmem_q.valid && exmem_q.op == OP_STORE) dmem[exmem_addr_q] <= exmem_sd_q;
  end
  assign dbg_rdata = rf[dbg_raddr];
  assign pc = pc_q;
  assign halted = halted_q;
  assign retired_cnt = cnt_q;
endmodule

// File: tb/tb_pipelined_cpu_core.sv
// tb_pipelined_cpu_core: directed programs with hand-computed register, pc, halt-timing and counter checks
module tb_pipelined_cpu_core;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic dmem_we = 1'b0;
  logic [3:0] dmem_addr = '0;
  logic [7:0] dmem_wdata = '0;
  logic [3:0] dbg_raddr = '0;
  logic [7:0] dbg_rdata;
  logic [3:0] pc;
  logic halted;
  logic [15:0] retired_cnt;
  int errors = 0;
  int checks = 0;
  int n;
  logic [15:0] prog [16];
  localparam logic [15:0] NOP = 16'h8000;
  localparam logic [15:0] HALT = 16'hf000;
  pipelined_cpu_core dut (
    .clk(clk),
    .reset_n(reset_n),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata),
    .pc(pc),
    .halted(halted),
    .retired_cnt(retired_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: observed no end expected end of run");
    $fatal(1);
  end
  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction
  function automatic logic [15:0] li(input logic [3:0] rd, input logic [7:0] v);
    return {4'h7, rd, v};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reg(input string tag, input logic [3:0] r, input logic [31:0] exp);
    dbg_raddr = r;
    #1;
    check(tag, 32'(dbg_rdata), exp);
  endtask
  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = NOP;
  endtask
  task automatic load_and_reset(input logic preload, input logic [7:0] pdata);
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1;
      prog_addr = 4'(i);
      prog_data = prog[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
    if (preload) begin
      dmem_we = 1'b1;
      dmem_addr = 4'd2;
      dmem_wdata = pdata;
      @(negedge clk);
      dmem_we = 1'b0;
    end
    @(negedge clk);
  endtask
  task automatic run_to_halt(output int cycles);
    reset_n = 1'b1;
    cycles = 0;
    while (!halted && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask
  initial begin
    clear_prog();
    prog[0] = li(4'd2, 8'd10);
    prog[1] = li(4'd3, 8'd5);
    prog[2] = li(4'd8, 8'd2);
    prog[3] = enc(4'h0, 4'd1, 4'd2, 4'd3);
    prog[4] = enc(4'h1, 4'd4, 4'd1, 4'd3);
    prog[5] = enc(4'h2, 4'd5, 4'd8, 4'd0);
    prog[6] = HALT;
    load_and_reset(1'b1, 8'd99);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_cnt", 32'(retired_cnt), 32'd0);
    chk_reg("reset_r1", 4'd1, 32'd0);
    run_to_halt(n);
    check("a_halt_cycles", 32'(n), 32'd11);
    chk_reg("a_r1_add", 4'd1, 32'd15);
    chk_reg("a_r4_sub_fwd", 4'd4, 32'd10);
    chk_reg("a_r5_load", 4'd5, 32'd99);
    check("a_retired", 32'(retired_cnt), 32'd7);
    check("a_pc_frozen", 32'(pc), 32'd7);
    clear_prog();
    prog[0] = li(4'd8, 8'd2);
    prog[1] = enc(4'h2, 4'd6, 4'd8, 4'd0);
    prog[2] = enc(4'h0, 4'd7, 4'd6, 4'd6);
    prog[3] = HALT;
    load_and_reset(1'b0, 8'd0);
    check("b_reset_halted", 32'(halted), 32'd0);
    chk_reg("b_reset_r1", 4'd1, 32'd0);
    run_to_halt(n);
    check("b_stall_halt_cycles", 32'(n), 32'd9);
    chk_reg("b_r7_loaduse", 4'd7, 32'd198);
    chk_reg("b_r6_load", 4'd6, 32'd99);
    check("b_retired", 32'(retired_cnt), 32'd4);
    clear_prog();
    prog[0] = li(4'd8, 8'd2);
    prog[1] = enc(4'h2, 4'd6, 4'd8, 4'd0);
    prog[2] = NOP;
    prog[3] = enc(4'h0, 4'd7, 4'd6, 4'd6);
    prog[4] = HALT;
    load_and_reset(1'b0, 8'd0);
    run_to_halt(n);
    check("b2_nop_halt_cycles", 32'(n), 32'd9);
    chk_reg("b2_r7", 4'd7, 32'd198);
    check("b2_retired", 32'(retired_cnt), 32'd5);
    clear_prog();
    prog[0] = li(4'd8, 8'd2);
    prog[1] = li(4'd1, 8'd15);
    prog[2] = enc(4'h3, 4'd0, 4'd8, 4'd1);
    prog[3] = enc(4'h2, 4'd9, 4'd8, 4'd0);
    prog[4] = HALT;
    load_and_reset(1'b0, 8'd0);
    run_to_halt(n);
    check("c_halt_cycles", 32'(n), 32'd9);
    chk_reg("c_r9_store_load", 4'd9, 32'd15);
    check("c_retired", 32'(retired_cnt), 32'd5);
    clear_prog();
    prog[0] = li(4'd2, 8'd10);
    prog[1] = li(4'd3, 8'd5);
    prog[2] = enc(4'h1, 4'd4, 4'd3, 4'd2);
    prog[3] = li(4'd5, 8'd200);
    prog[4] = li(4'd6, 8'd100);
    prog[5] = enc(4'h0, 4'd7, 4'd5, 4'd6);
    prog[6] = li(4'd8, 8'd2);
    prog[7] = enc(4'h2, 4'd10, 4'd8, 4'd0);
    prog[8] = enc(4'h6, 4'd12, 4'd5, 4'd6);
    prog[9] = HALT;
    load_and_reset(1'b0, 8'd0);
    run_to_halt(n);
    check("d_halt_cycles", 32'(n), 32'd14);
    chk_reg("d_r4_sub_wrap", 4'd4, 32'd251);
    chk_reg("d_r7_add_wrap", 4'd7, 32'd44);
    chk_reg("d_r10_dmem2", 4'd10, 32'd15);
    chk_reg("d_r12_xor", 4'd12, 32'd172);
    clear_prog();
    load_and_reset(1'b0, 8'd0);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("w_pc15", 32'(pc), 32'd15);
    @(negedge clk);
    check("w_pc_wrap0", 32'(pc), 32'd0);
    @(negedge clk);
    check("w_pc1", 32'(pc), 32'd1);
    check("w_retired", 32'(retired_cnt), 32'd13);
    check("w_not_halted", 32'(halted), 32'd0);
    clear_prog();
    prog[0] = HALT;
    prog[1] = li(4'd11, 8'h77);
    load_and_reset(1'b0, 8'd0);
    run_to_halt(n);
    check("e_halt_cycles", 32'(n), 32'd5);
    check("e_retired", 32'(retired_cnt), 32'd1);
    repeat (3) @(negedge clk);
    check("e_pc_frozen", 32'(pc), 32'd1);
    check("e_halted_sticky", 32'(halted), 32'd1);
    chk_reg("e_r11_untouched", 4'd11, 32'd0);
    clear_prog();
    prog[0] = li(4'd2, 8'd10);
    prog[1] = li(4'd3, 8'd5);
    prog[2] = li(4'd8, 8'd2);
    prog[3] = enc(4'h0, 4'd1, 4'd2, 4'd3);
    prog[4] = enc(4'h1, 4'd4, 4'd1, 4'd3);
    prog[5] = enc(4'h2, 4'd5, 4'd8, 4'd0);
    prog[6] = HALT;
    load_and_reset(1'b1, 8'd99);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_reg("m_r2_before", 4'd2, 32'd10);
    check("m_cnt_before", 32'(retired_cnt), 32'd2);
    reset_n = 1'b0;
    @(negedge clk);
    check("m_pc_reset", 32'(pc), 32'd0);
    check("m_halted_reset", 32'(halted), 32'd0);
    check("m_cnt_reset", 32'(retired_cnt), 32'd0);
    chk_reg("m_r2_reset", 4'd2, 32'd0);
    run_to_halt(n);
    check("m_halt_cycles", 32'(n), 32'd11);
    chk_reg("m_r1", 4'd1, 32'd15);
    chk_reg("m_r4", 4'd4, 32'd10);
    chk_reg("m_r5", 4'd5, 32'd99);
    check("m_retired", 32'(retired_cnt), 32'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
